fifo_si_word_bridge: RTL and testbench
======================================

Name: fifo_si_word_bridge

Overview:
Parametrised bridge between the byte-wide FIFO simple interface and the decoder.
- RX path: packs BYTES consecutive bytes into one word and presents it on a valid/ready port.
- TX path: splits decoder words into bytes and drives the simple-interface TX side.
- Adds byte ordering, decoder back-pressure, and a partial-word flush timeout.

Parameters:
BYTES, 2, bytes per decoder word (1..8); word width W = 8*BYTES.
BIG_ENDIAN, 0, 0: first byte on the wire goes to word[7:0]; 1: first byte goes to word[W-1:W-8]. Applies to both paths.
TIMEOUT, 1000, idle clk cycles before a partial RX word is flushed; 0 disables the flush.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
rx_data_si  in  8  RX byte from FIFO, valid while rx_rdy_si=1
rx_rdy_si  in  1  FIFO has an RX byte
rx_ack_si  out  1  one-cycle pulse, consumes the RX byte
tx_data_si  out  8  TX byte to FIFO
tx_rdy_si  out  1  TX byte offered, held until acked
tx_ack_si  in  1  FIFO accepted the TX byte
rx_word  out  W  assembled word to decoder
rx_valid  out  1  rx_word valid
rx_ready  in  1  decoder accepts rx_word
rx_partial  out  1  qualifies rx_word: word was flushed by timeout
tx_word  in  W  word from decoder
tx_valid  in  1  tx_word valid
tx_ready  out  1  bridge accepts tx_word

Behaviour:
Reset: all outputs are 0. Byte counters, timeout counter and holding registers are cleared. Both FSMs go to IDLE.

Reset mid-operation discards any partial or unsent data. Nothing is replayed after reset.

RX FSM, states R_IDLE, R_ACK, R_GAP, R_OUT:
- R_IDLE: if rx_rdy_si=1 and the output register is free, go to R_ACK.
- R_ACK: rx_ack_si=1 for exactly this cycle. rx_data_si is captured at the end of this cycle into lane idx (ordered per BIG_ENDIAN). idx increments.
- After R_ACK:
  - if idx reaches BYTES, go to R_OUT;
  - otherwise go to R_GAP.
- R_GAP: one mandatory idle cycle, then return to R_IDLE.
- R_OUT: rx_valid=1 with rx_partial=0. Hold rx_word and rx_valid stable until rx_ready=1 is sampled. On that cycle clear idx and return to R_IDLE. rx_ack_si stays 0 while in R_OUT.
- Back-to-back minimum: one byte per 3 cycles (IDLE, ACK, GAP).

Timeout (TIMEOUT>0):
- The counter runs only while 0<idx<BYTES and the FSM is in R_IDLE. It resets on every captured byte.
- When it reaches TIMEOUT, go to R_OUT with rx_partial=1. Unfilled lanes are 0.
- If rx_rdy_si=1 in the same cycle the counter reaches TIMEOUT, the byte wins and the flush does not occur.
- BYTES=1 never times out.

TX FSM, states T_IDLE, T_SEND, T_GAP:
- T_IDLE: tx_ready=1.
  - On tx_valid=1 and tx_ready=1, latch tx_word, set the byte index to 0 and go to T_SEND.
  - tx_ready=0 in every other state.
- T_SEND: tx_rdy_si=1, with tx_data_si = the current lane per BIG_ENDIAN. Both are held stable until tx_ack_si=1 is sampled.
  - On ack, drop tx_rdy_si on the next cycle and go to T_GAP.
  - If this was the last byte, go to T_IDLE instead.
- T_GAP: one cycle with tx_rdy_si=0, then go to T_SEND with the next byte.
- tx_ack_si while tx_rdy_si=0 is ignored.

RX and TX paths are fully independent and may run simultaneously.

An undefined state encoding recovers to IDLE on the next cycle.

Test Plan:
1. BYTES=2, BIG_ENDIAN=0, rx_ready=1, bytes 0x34 then 0x12:
   - rx_ack_si pulses are single-cycle, at least 3 cycles apart;
   - rx_valid=1 for 1 cycle with rx_word=0x1234 and rx_partial=0.
2. Same bytes with BIG_ENDIAN=1 -> rx_word=0x3412.
3. Back-pressure: rx_ready=0 and rx_rdy_si held 1:
   - exactly 2 acks, then rx_word=0x1234 held stable with no further ack;
   - raising rx_ready for 1 cycle causes the third ack to follow.
4. Timeout, TIMEOUT=8, BYTES=4: one byte 0xAA, then rx_rdy_si=0:
   - exactly 8 cycles after the R_GAP→R_IDLE transition, rx_valid=1, rx_partial=1, rx_word=0x000000AA.
5. Timeout collision: rx_rdy_si rises in the cycle the counter hits TIMEOUT -> no flush; the byte lands in lane 1.
6. TX path, BYTES=2, BIG_ENDIAN=0, tx_word=0xBEEF, FIFO acks after 3 cycles:
   - tx_data_si=0xEF is held until acked, then 0xBE;
   - tx_ready returns 1 only after the second ack;
   - assert rst during the first byte -> tx_rdy_si=0 on the next cycle and tx_ready=1 after reset.

Source files
------------

// File: rtl/fifo_si_word_bridge.sv
// fifo_si_word_bridge
// Bridges the byte-wide FIFO simple interface to a word-wide decoder port.
//   RX: packs BYTES bytes from the FIFO into rx_word (valid/ready).
//       A partial word is flushed after TIMEOUT idle cycles and is then
//       qualified by rx_partial.
//   TX: splits tx_word into BYTES bytes and offers them to the FIFO one at
//       a time.
// BIG_ENDIAN chooses which end of the word the first wire byte maps to.
// It applies to both paths.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   rx_data_si, rx_rdy_si, rx_ack_si FIFO RX byte side
//   tx_data_si, tx_rdy_si, tx_ack_si FIFO TX byte side
//   rx_word, rx_valid, rx_ready      decoder RX word side
//   rx_partial                       rx_word was flushed by timeout
//   tx_word, tx_valid, tx_ready      decoder TX word side
//
// RX FSM
//   state  | meaning
//   R_IDLE | wait for a byte or for the flush timeout
//   R_ACK  | rx_ack_si high, byte captured at end of cycle
//   R_GAP  | mandatory idle cycle after each byte
//   R_OUT  | word presented, waiting for rx_ready
// TX FSM
//   state  | meaning
//   T_IDLE | tx_ready high, waiting for a decoder word
//   T_SEND | byte offered on tx_rdy_si until acked
//   T_GAP  | one idle cycle between bytes
module fifo_si_word_bridge #(
  parameter int BYTES      = 2,
  parameter bit BIG_ENDIAN = 1'b0,
  parameter int TIMEOUT    = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data_si,
  input  logic               rx_rdy_si,
  output logic               rx_ack_si,
  output logic [7:0]         tx_data_si,
  output logic               tx_rdy_si,
  input  logic               tx_ack_si,
  output logic [8*BYTES-1:0] rx_word,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic               rx_partial,
  input  logic [8*BYTES-1:0] tx_word,
  input  logic               tx_valid,
  output logic               tx_ready
);

  localparam int W  = 8 * BYTES;
  localparam int IW = $clog2(BYTES + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] IDX_FULL = IW'(BYTES);
  localparam logic [IW-1:0] IDX_LAST = IW'(BYTES - 1);
  // The flush fires on the last counted idle cycle, so the word appears
  // exactly TIMEOUT cycles after the FSM re-entered R_IDLE.
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  function automatic int lane_lsb(input int lane);
    return BIG_ENDIAN ? 8 * (BYTES - 1 - lane) : 8 * lane;
  endfunction

  function automatic logic [7:0] lane_of(input logic [W-1:0] w, input logic [IW-1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < BYTES; i++)
      if (idx == IW'(i)) b = w[lane_lsb(i) +: 8];
    return b;
  endfunction

  // ---------------- RX path ----------------
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_GAP, R_OUT} r_state_t;

  r_state_t      r_state;
  logic [IW-1:0] r_idx;
  logic [TW-1:0] r_tcnt;
  logic          r_waiting;
  logic          r_flush;

  assign r_waiting = (r_idx != '0) && (r_idx < IDX_FULL);
  assign r_flush   = (TIMEOUT != 0) && r_waiting && (r_tcnt == T_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= R_IDLE;
      r_idx      <= '0;
      r_tcnt     <= '0;
      rx_word    <= '0;
      rx_valid   <= 1'b0;
      rx_partial <= 1'b0;
      rx_ack_si  <= 1'b0;
    end else begin
      rx_ack_si <= 1'b0;
      case (r_state)
        R_IDLE: begin
          // An arriving byte takes priority over a flush due in this cycle.
          if (rx_rdy_si) begin
            r_state   <= R_ACK;
            rx_ack_si <= 1'b1;
            r_tcnt    <= '0;
          end else if (r_flush) begin
            r_state    <= R_OUT;
            rx_valid   <= 1'b1;
            rx_partial <= 1'b1;
            r_tcnt     <= '0;
          end else if (r_waiting && (TIMEOUT != 0)) begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        R_ACK: begin
          for (int i = 0; i < BYTES; i++)
            if (r_idx == IW'(i)) rx_word[lane_lsb(i) +: 8] <= rx_data_si;
          r_idx  <= r_idx + 1'b1;
          r_tcnt <= '0;
          if (r_idx == IDX_LAST) begin
            r_state    <= R_OUT;
            rx_valid   <= 1'b1;
            rx_partial <= 1'b0;
          end else begin
            r_state <= R_GAP;
          end
        end
        R_GAP: r_state <= R_IDLE;
        R_OUT: begin
          // Clearing the word here keeps unfilled lanes of a later flush at 0.
          if (rx_ready) begin
            r_state    <= R_IDLE;
            rx_valid   <= 1'b0;
            rx_partial <= 1'b0;
            r_idx      <= '0;
            rx_word    <= '0;
          end
        end
        default: begin
          r_state    <= R_IDLE;
          r_idx      <= '0;
          r_tcnt     <= '0;
          rx_valid   <= 1'b0;
          rx_partial <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- TX path ----------------
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_GAP} t_state_t;

  t_state_t      t_state;
  logic [W-1:0]  t_buf;
  logic [IW-1:0] t_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      t_state    <= T_IDLE;
      t_buf      <= '0;
      t_idx      <= '0;
      tx_ready   <= 1'b0;
      tx_rdy_si  <= 1'b0;
      tx_data_si <= 8'h00;
    end else begin
      case (t_state)
        T_IDLE: begin
          if (tx_valid && tx_ready) begin
            t_buf      <= tx_word;
            t_idx      <= '0;
            tx_ready   <= 1'b0;
            tx_rdy_si  <= 1'b1;
            tx_data_si <= lane_of(tx_word, IW'(0));
            t_state    <= T_SEND;
          end else begin
            tx_ready <= 1'b1;
          end
        end
        T_SEND: begin
          if (tx_ack_si) begin
            tx_rdy_si <= 1'b0;
            if (t_idx == IDX_LAST) begin
              t_state  <= T_IDLE;
              tx_ready <= 1'b1;
            end else begin
              t_state <= T_GAP;
              t_idx   <= t_idx + 1'b1;
            end
          end
        end
        T_GAP: begin
          tx_rdy_si  <= 1'b1;
          tx_data_si <= lane_of(t_buf, t_idx);
          t_state    <= T_SEND;
        end
        default: begin
          t_state   <= T_IDLE;
          tx_ready  <= 1'b0;
          tx_rdy_si <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_si_word_bridge.sv
module tb_fifo_si_word_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // shared stimulus for dut_a (little endian) and dut_b (big endian)
  logic [7:0]  rx_data_si;
  logic        rx_rdy_si, rx_ready;
  logic [15:0] tx_word;
  logic        tx_valid, tx_ack_si;

  logic        a_rx_ack, a_tx_rdy, a_rx_valid, a_rx_partial, a_tx_ready;
  logic [7:0]  a_tx_data;
  logic [15:0] a_rx_word;
  logic        b_rx_ack, b_tx_rdy, b_rx_valid, b_rx_partial, b_tx_ready;
  logic [7:0]  b_tx_data;
  logic [15:0] b_rx_word;

  // dut_c: 4 bytes, TIMEOUT=8
  logic [7:0]  c_rx_data, c_tx_data;
  logic        c_rx_rdy, c_rx_ready, c_rx_ack, c_tx_rdy, c_tx_ack;
  logic [31:0] c_rx_word, c_tx_word;
  logic        c_rx_valid, c_rx_partial, c_tx_valid, c_tx_ready;

  fifo_si_word_bridge #(.BYTES(2), .BIG_ENDIAN(1'b0), .TIMEOUT(1000)) dut_a (
    .clk(clk), .rst(rst),
    .rx_data_si(rx_data_si), .rx_rdy_si(rx_rdy_si), .rx_ack_si(a_rx_ack),
    .tx_data_si(a_tx_data), .tx_rdy_si(a_tx_rdy), .tx_ack_si(tx_ack_si),
    .rx_word(a_rx_word), .rx_valid(a_rx_valid), .rx_ready(rx_ready),
    .rx_partial(a_rx_partial),
    .tx_word(tx_word), .tx_valid(tx_valid), .tx_ready(a_tx_ready));

  fifo_si_word_bridge #(.BYTES(2), .BIG_ENDIAN(1'b1), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst),
    .rx_data_si(rx_data_si), .rx_rdy_si(rx_rdy_si), .rx_ack_si(b_rx_ack),
    .tx_data_si(b_tx_data), .tx_rdy_si(b_tx_rdy), .tx_ack_si(tx_ack_si),
    .rx_word(b_rx_word), .rx_valid(b_rx_valid), .rx_ready(rx_ready),
    .rx_partial(b_rx_partial),
    .tx_word(tx_word), .tx_valid(tx_valid), .tx_ready(b_tx_ready));

  fifo_si_word_bridge #(.BYTES(4), .BIG_ENDIAN(1'b0), .TIMEOUT(8)) dut_c (
    .clk(clk), .rst(rst),
    .rx_data_si(c_rx_data), .rx_rdy_si(c_rx_rdy), .rx_ack_si(c_rx_ack),
    .tx_data_si(c_tx_data), .tx_rdy_si(c_tx_rdy), .tx_ack_si(c_tx_ack),
    .rx_word(c_rx_word), .rx_valid(c_rx_valid), .rx_ready(c_rx_ready),
    .rx_partial(c_rx_partial),
    .tx_word(c_tx_word), .tx_valid(c_tx_valid), .tx_ready(c_tx_ready));

  int npass = 0;
  int ntotal = 0;

  // FIFO source models: a byte is consumed on the edge that samples its ack.
  logic [7:0] ab_q [8];
  int         ab_len, ab_ptr;
  logic       ab_prev_ack;
  logic [7:0] c_q [8];
  int         c_at [8];
  int         c_len, c_ptr, c_cyc;
  logic       c_prev_ack;

  // expected per-cycle traces, index = cycle after stimulus start
  localparam bit [1:6]  T1_ACK = 6'b100100;
  localparam bit [1:6]  T1_VAL = 6'b000010;
  localparam bit [1:10] T3_ACK = 10'b1001000000;
  localparam bit [1:10] T3_VAL = 10'b0000111111;
  localparam bit [1:12] T4_ACK = 12'b100000000000;
  localparam bit [1:12] T4_VAL = 12'b000000000010;
  localparam bit [1:19] T5_ACK = 19'b1000000000100100100;
  localparam bit [1:19] T5_VAL = 19'b0000000000000000010;
  localparam bit [1:8]  T6_RDY = 8'b11101110;
  localparam bit [1:8]  T6_RDYW = 8'b00000001;
  localparam bit [1:8]  T6_ACKDRV = 8'b00110010;

  task automatic drive_fifos();
    if (ab_ptr < ab_len) begin
      rx_rdy_si  = 1'b1;
      rx_data_si = ab_q[ab_ptr];
    end else begin
      rx_rdy_si  = 1'b0;
      rx_data_si = 8'h00;
    end
    if (c_ptr < c_len) begin
      c_rx_rdy  = (c_cyc >= c_at[c_ptr]);
      c_rx_data = c_q[c_ptr];
    end else begin
      c_rx_rdy  = 1'b0;
      c_rx_data = 8'h00;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (ab_prev_ack) ab_ptr++;
    ab_prev_ack = a_rx_ack;
    if (c_prev_ack) c_ptr++;
    c_prev_ack = c_rx_ack;
    c_cyc++;
    drive_fifos();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    ntotal++;
    if ({a_rx_ack, a_tx_data, a_tx_rdy, a_rx_word, a_rx_valid, a_rx_partial, a_tx_ready} !== 29'd0)
      $display("FAIL reset_a: outputs %h, required 0",
               {a_rx_ack, a_tx_data, a_tx_rdy, a_rx_word, a_rx_valid, a_rx_partial, a_tx_ready});
    else npass++;
    ntotal++;
    if ({b_rx_ack, b_tx_data, b_tx_rdy, b_rx_word, b_rx_valid, b_rx_partial, b_tx_ready} !== 29'd0)
      $display("FAIL reset_b: outputs %h, required 0",
               {b_rx_ack, b_tx_data, b_tx_rdy, b_rx_word, b_rx_valid, b_rx_partial, b_tx_ready});
    else npass++;
    ntotal++;
    if ({c_rx_ack, c_tx_data, c_tx_rdy, c_rx_word, c_rx_valid, c_rx_partial, c_tx_ready} !== 45'd0)
      $display("FAIL reset_c: outputs %h, required 0",
               {c_rx_ack, c_tx_data, c_tx_rdy, c_rx_word, c_rx_valid, c_rx_partial, c_tx_ready});
    else npass++;
    rst = 1'b0;
    tick();
    ntotal++;
    if ({a_tx_ready, b_tx_ready, c_tx_ready} !== 3'b111)
      $display("FAIL reset_tx_ready: got %b, required 111", {a_tx_ready, b_tx_ready, c_tx_ready});
    else npass++;
    ntotal++;
    if ({a_rx_valid, a_rx_ack, c_rx_valid, c_rx_ack} !== 4'b0000)
      $display("FAIL reset_rx_idle: got %b, required 0000", {a_rx_valid, a_rx_ack, c_rx_valid, c_rx_ack});
    else npass++;
  endtask

  // bytes 0x34 then 0x12: LE -> 0x1234, BE -> 0x3412
  task automatic test_rx_pack();
    ab_q[0] = 8'h34; ab_q[1] = 8'h12;
    ab_len = 2; ab_ptr = 0; ab_prev_ack = 1'b0;
    rx_ready = 1'b1;
    drive_fifos();
    for (int c = 1; c <= 6; c++) begin
      tick();
      ntotal++;
      if ({a_rx_ack, b_rx_ack} !== {2{T1_ACK[c]}})
        $display("FAIL pack_ack cycle %0d: a=%b b=%b, required %b", c, a_rx_ack, b_rx_ack, T1_ACK[c]);
      else npass++;
      ntotal++;
      if ({a_rx_valid, b_rx_valid} !== {2{T1_VAL[c]}})
        $display("FAIL pack_valid cycle %0d: a=%b b=%b, required %b", c, a_rx_valid, b_rx_valid, T1_VAL[c]);
      else npass++;
      if (T1_VAL[c]) begin
        ntotal++;
        if (a_rx_word !== 16'h1234 || a_rx_partial !== 1'b0)
          $display("FAIL pack_le_word: got %h partial %b, required 1234 partial 0", a_rx_word, a_rx_partial);
        else npass++;
        ntotal++;
        if (b_rx_word !== 16'h3412 || b_rx_partial !== 1'b0)
          $display("FAIL pack_be_word: got %h partial %b, required 3412 partial 0", b_rx_word, b_rx_partial);
        else npass++;
      end
    end
  endtask

  task automatic test_backpressure();
    ab_q[0] = 8'h34; ab_q[1] = 8'h12; ab_q[2] = 8'h56;
    ab_len = 3; ab_ptr = 0; ab_prev_ack = 1'b0;
    rx_ready = 1'b0;
    drive_fifos();
    for (int c = 1; c <= 10; c++) begin
      tick();
      ntotal++;
      if ({a_rx_ack, b_rx_ack} !== {2{T3_ACK[c]}})
        $display("FAIL bp_ack cycle %0d: a=%b b=%b, required %b", c, a_rx_ack, b_rx_ack, T3_ACK[c]);
      else npass++;
      ntotal++;
      if ({a_rx_valid, b_rx_valid} !== {2{T3_VAL[c]}})
        $display("FAIL bp_valid cycle %0d: a=%b b=%b, required %b", c, a_rx_valid, b_rx_valid, T3_VAL[c]);
      else npass++;
      if (T3_VAL[c]) begin
        ntotal++;
        if (a_rx_word !== 16'h1234 || b_rx_word !== 16'h3412)
          $display("FAIL bp_hold cycle %0d: a=%h b=%h, required 1234 3412", c, a_rx_word, b_rx_word);
        else npass++;
      end
    end
    rx_ready = 1'b1;
    tick();
    ntotal++;
    if ({a_rx_valid, a_rx_ack} !== 2'b00)
      $display("FAIL bp_release: valid=%b ack=%b, required 0 0", a_rx_valid, a_rx_ack);
    else npass++;
    rx_ready = 1'b0;
    tick();
    ntotal++;
    if ({a_rx_ack, b_rx_ack} !== 2'b11)
      $display("FAIL bp_third_ack: a=%b b=%b, required 1 1", a_rx_ack, b_rx_ack);
    else npass++;
    repeat (3) tick();
  endtask

  task automatic test_timeout();
    c_q[0] = 8'hAA; c_at[0] = 0;
    c_len = 1; c_ptr = 0; c_cyc = 0; c_prev_ack = 1'b0;
    c_rx_ready = 1'b1;
    drive_fifos();
    for (int c = 1; c <= 12; c++) begin
      tick();
      ntotal++;
      if (c_rx_ack !== T4_ACK[c])
        $display("FAIL to_ack cycle %0d: got %b, required %b", c, c_rx_ack, T4_ACK[c]);
      else npass++;
      ntotal++;
      if (c_rx_valid !== T4_VAL[c])
        $display("FAIL to_valid cycle %0d: got %b, required %b", c, c_rx_valid, T4_VAL[c]);
      else npass++;
      if (T4_VAL[c]) begin
        ntotal++;
        if (c_rx_word !== 32'h000000AA || c_rx_partial !== 1'b1)
          $display("FAIL to_word: got %h partial %b, required 000000aa partial 1", c_rx_word, c_rx_partial);
        else npass++;
      end
    end
    ntotal++;
    if (c_rx_partial !== 1'b0)
      $display("FAIL to_partial_clear: got %b, required 0", c_rx_partial);
    else npass++;
  endtask

  // second byte arrives in the cycle the counter would flush
  task automatic test_timeout_collision();
    c_q[0] = 8'h11; c_q[1] = 8'h22; c_q[2] = 8'h33; c_q[3] = 8'h44;
    c_at[0] = 0; c_at[1] = 10; c_at[2] = 0; c_at[3] = 0;
    c_len = 4; c_ptr = 0; c_cyc = 0; c_prev_ack = 1'b0;
    c_rx_ready = 1'b1;
    drive_fifos();
    for (int c = 1; c <= 19; c++) begin
      tick();
      ntotal++;
      if (c_rx_ack !== T5_ACK[c])
        $display("FAIL col_ack cycle %0d: got %b, required %b", c, c_rx_ack, T5_ACK[c]);
      else npass++;
      ntotal++;
      if (c_rx_valid !== T5_VAL[c])
        $display("FAIL col_valid cycle %0d: got %b, required %b", c, c_rx_valid, T5_VAL[c]);
      else npass++;
      if (T5_VAL[c]) begin
        ntotal++;
        if (c_rx_word !== 32'h44332211 || c_rx_partial !== 1'b0)
          $display("FAIL col_word: got %h partial %b, required 44332211 partial 0", c_rx_word, c_rx_partial);
        else npass++;
      end
    end
  endtask

  task automatic test_tx();
    ab_len = 0; ab_ptr = 0; ab_prev_ack = 1'b0;
    rx_ready = 1'b1;
    drive_fifos();
    tx_word = 16'hBEEF;
    tx_valid = 1'b1;
    tx_ack_si = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      tx_valid = 1'b0;
      ntotal++;
      if ({a_tx_rdy, b_tx_rdy} !== {2{T6_RDY[c]}})
        $display("FAIL tx_rdy cycle %0d: a=%b b=%b, required %b", c, a_tx_rdy, b_tx_rdy, T6_RDY[c]);
      else npass++;
      ntotal++;
      if ({a_tx_ready, b_tx_ready} !== {2{T6_RDYW[c]}})
        $display("FAIL tx_ready cycle %0d: a=%b b=%b, required %b", c, a_tx_ready, b_tx_ready, T6_RDYW[c]);
      else npass++;
      if (T6_RDY[c]) begin
        ntotal++;
        if (a_tx_data !== ((c < 4) ? 8'hEF : 8'hBE))
          $display("FAIL tx_le_data cycle %0d: got %h, required %h", c, a_tx_data, (c < 4) ? 8'hEF : 8'hBE);
        else npass++;
        ntotal++;
        if (b_tx_data !== ((c < 4) ? 8'hBE : 8'hEF))
          $display("FAIL tx_be_data cycle %0d: got %h, required %h", c, b_tx_data, (c < 4) ? 8'hBE : 8'hEF);
        else npass++;
      end
      tx_ack_si = T6_ACKDRV[c];
    end
    tx_ack_si = 1'b0;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    ntotal++;
    if (a_tx_rdy !== 1'b1 || a_tx_data !== 8'hEF)
      $display("FAIL tx_second_word: rdy=%b data=%h, required 1 ef", a_tx_rdy, a_tx_data);
    else npass++;
    rst = 1'b1;
    tick();
    ntotal++;
    if ({a_tx_rdy, a_tx_ready, b_tx_rdy} !== 3'b000)
      $display("FAIL tx_rst_drop: rdy=%b ready=%b b_rdy=%b, required 000", a_tx_rdy, a_tx_ready, b_tx_rdy);
    else npass++;
    rst = 1'b0;
    tick();
    ntotal++;
    if ({a_tx_ready, b_tx_ready} !== 2'b11)
      $display("FAIL tx_rst_ready: a=%b b=%b, required 11", a_tx_ready, b_tx_ready);
    else npass++;
    for (int c = 0; c < 3; c++) begin
      tick();
      ntotal++;
      if (a_tx_rdy !== 1'b0)
        $display("FAIL tx_no_replay cycle %0d: got %b, required 0", c, a_tx_rdy);
      else npass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    rx_ready = 1'b0; tx_word = 16'h0; tx_valid = 1'b0; tx_ack_si = 1'b0;
    c_rx_ready = 1'b0; c_tx_word = 32'h0; c_tx_valid = 1'b0; c_tx_ack = 1'b0;
    ab_len = 0; ab_ptr = 0; ab_prev_ack = 1'b0;
    c_len = 0; c_ptr = 0; c_cyc = 0; c_prev_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ab_q[i] = 8'h00; c_q[i] = 8'h00; c_at[i] = 0;
    end
    drive_fifos();
    test_reset();
    test_rx_pack();
    test_backpressure();
    test_timeout();
    test_timeout_collision();
    test_tx();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
